// File: rtl/si_wr_sink.sv
// si_wr_sink: write-slave sink; FIFOs ADC burst writes and drains them into a capture memory.
// Latency: write in cycle N is readable on rd_data in cycle N+2 when FIFO empty and drain timer idle.
// Backpressure: none towards the driver; writes arriving on a full FIFO are dropped and flagged in overflow.

// si_fifo: generic single-clock FIFO with valid/ready on both sides.
// Latency: one cycle from push to out_vld; out_dat is a combinational read of the head entry.
// Backpressure: in_rdy low when full; an entry is popped only when out_rdy is high.
module si_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty when the indices match.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] store [DEPTH];
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign in_rdy  = !full;
    assign out_vld = !empty;
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;
    assign out_dat = store[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr[AW-1:0]] <= in_dat;
    end
endmodule

module si_wr_sink #(
    parameter int FIFO_DEPTH = 4,
    parameter int DRAIN_WAIT = 2,
    parameter int MEM_WORDS  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exec,
    input  logic        we,
    input  logic [8:0]  si_address,
    input  logic [31:0] si_data,
    output logic        fin,
    input  logic [5:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic [15:0] word_cnt,
    output logic [31:0] checksum,
    output logic        overflow
);
    localparam int TW = (DRAIN_WAIT > 0) ? $clog2(DRAIN_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] dat;
    } cmd_t;

    state_t      state;
    logic [TW-1:0] drain_tmr;
    logic        wr_vld;
    logic        wr_rdy;
    cmd_t        wr_cmd;
    logic        head_vld;
    logic        head_rdy;
    cmd_t        head_cmd;
    logic        pop;
    logic [31:0] mem [MEM_WORDS];
    logic        unused_addr_bits;

    // Byte-lane bits of the address carry no meaning for word writes.
    assign unused_addr_bits = ^si_address[1:0];

    assign wr_vld   = exec && we && si_address[8];
    assign wr_cmd   = '{idx: si_address[7:2], dat: si_data};
    // Reset blocks the drain so a reset edge never commits a stale head entry.
    assign head_rdy = (drain_tmr == '0) && !reset;
    assign pop      = head_vld && head_rdy;

    si_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (wr_vld),
        .in_rdy  (wr_rdy),
        .in_dat  (wr_cmd),
        .out_vld (head_vld),
        .out_rdy (head_rdy),
        .out_dat (head_cmd)
    );

    always_ff @(posedge clk) begin
        if (pop) mem[head_cmd.idx] <= head_cmd.dat;
    end

    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            drain_tmr <= '0;
            word_cnt  <= '0;
            checksum  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (pop) begin
                drain_tmr <= TW'(DRAIN_WAIT);
                word_cnt  <= word_cnt + 1'b1;
                checksum  <= checksum + head_cmd.dat;
            end else if (drain_tmr != '0) begin
                drain_tmr <= drain_tmr - 1'b1;
            end
            if (wr_vld && !wr_rdy) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            fin   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_vld) begin
                        state <= ST_BUSY;
                        fin   <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (!head_vld && drain_tmr == '0 && !wr_vld) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (wr_vld) begin
                        state <= ST_BUSY;
                    end else begin
                        state <= ST_IDLE;
                        fin   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    fin   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_si_wr_sink.sv
// Bench for si_wr_sink: two instances (drain wait 2 and 0) share stimulus; a queue model predicts
// accepted writes, and a monitor checks each commit against the scoreboard.
module tb_si_wr_sink;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        exec = 1'b0;
    logic        we = 1'b0;
    logic [8:0]  si_address = '0;
    logic [31:0] si_data = '0;
    logic [5:0]  rd_addr_v [2];
    logic        fin_w [2];
    logic [31:0] rd_data_w [2];
    logic [15:0] word_cnt_w [2];
    logic [31:0] checksum_w [2];
    logic        overflow_w [2];
    logic [5:0]  rb_idx = '0;

    always #5 clk = ~clk;

    si_wr_sink #(.FIFO_DEPTH(DEPTH), .DRAIN_WAIT(2), .MEM_WORDS(64)) u_dut_w2 (
        .clk(clk), .reset(reset), .exec(exec), .we(we), .si_address(si_address),
        .si_data(si_data), .fin(fin_w[0]), .rd_addr(rd_addr_v[0]), .rd_data(rd_data_w[0]),
        .word_cnt(word_cnt_w[0]), .checksum(checksum_w[0]), .overflow(overflow_w[0])
    );

    si_wr_sink #(.FIFO_DEPTH(DEPTH), .DRAIN_WAIT(0), .MEM_WORDS(64)) u_dut_w0 (
        .clk(clk), .reset(reset), .exec(exec), .we(we), .si_address(si_address),
        .si_data(si_data), .fin(fin_w[1]), .rd_addr(rd_addr_v[1]), .rd_data(rd_data_w[1]),
        .word_cnt(word_cnt_w[1]), .checksum(checksum_w[1]), .overflow(overflow_w[1])
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: pending FIFO contents, drain timer, burst state, sticky flags.
    logic [37:0] mq [2][$];
    logic [37:0] sb [2][$];
    int          m_tmr [2] = '{0, 0};
    int          m_st  [2] = '{0, 0};
    logic        m_fin [2] = '{1'b1, 1'b1};
    logic        m_ovf [2] = '{1'b0, 1'b0};
    int          m_acc [2] = '{0, 0};
    logic [31:0] sh [2][64];
    bit          sh_vld [2][64];

    function automatic int dw_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%08h, expected 0x%08h", name, d, act, exp);
        end
    endtask

    task automatic model_step(input int d, input logic r, input logic vw, input logic [37:0] ent);
        int occ;
        int tmr;
        occ = mq[d].size();
        tmr = m_tmr[d];
        if (r) begin
            mq[d].delete();
            sb[d].delete();
            m_tmr[d] = 0;
            m_st[d]  = 0;
            m_fin[d] = 1'b1;
            m_ovf[d] = 1'b0;
            m_acc[d] = 0;
        end else begin
            if (occ > 0 && tmr == 0) begin
                mq[d].delete(0);
                m_tmr[d] = dw_of(d);
            end else if (tmr > 0) begin
                m_tmr[d] = tmr - 1;
            end
            if (vw) begin
                if (occ < DEPTH) begin
                    mq[d].push_back(ent);
                    sb[d].push_back(ent);
                    m_acc[d]++;
                end else begin
                    m_ovf[d] = 1'b1;
                end
            end
            case (m_st[d])
                0: if (vw) begin m_st[d] = 1; m_fin[d] = 1'b0; end
                1: if (occ == 0 && tmr == 0 && !vw) m_st[d] = 2;
                default: begin
                    if (vw) m_st[d] = 1;
                    else begin m_st[d] = 0; m_fin[d] = 1'b1; end
                end
            endcase
        end
    endtask

    task automatic cyc(input logic e, input logic w, input logic [8:0] a, input logic [31:0] dt, input logic r);
        logic vw;
        exec = e;
        we = w;
        si_address = a;
        si_data = dt;
        reset = r;
        vw = e & w & a[8];
        for (int d = 0; d < 2; d++) model_step(d, r, vw, {a[7:2], dt});
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("fin", d, 32'(fin_w[d]), 32'(m_fin[d]));
            chk("overflow", d, 32'(overflow_w[d]), 32'(m_ovf[d]));
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 9'h000, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 9'h000, 32'h0, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 300 && (m_st[0] != 0 || m_st[1] != 0 || mq[0].size() != 0 ||
                           mq[1].size() != 0 || m_tmr[0] != 0 || m_tmr[1] != 0)) begin
            idle();
            n++;
        end
        if (n >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", n);
        end
        idle();
        idle();
    endtask

    task automatic readback(input bit burst_pattern);
        for (int i = 0; i < 64; i++) begin
            rb_idx = 6'(i);
            idle();
            for (int d = 0; d < 2; d++)
                if (sh_vld[d][i]) chk("readback", d, rd_data_w[d], sh[d][i]);
            if (burst_pattern) chk("burst_mem", 1, rd_data_w[1], 32'(i));
        end
    endtask

    // Monitor: each committed word must match the oldest accepted write.
    initial begin
        logic [15:0] prev [2];
        int          ecnt [2];
        logic [31:0] esum [2];
        logic [37:0] h;
        for (int d = 0; d < 2; d++) begin
            rd_addr_v[d] = '0;
            prev[d] = '0;
            ecnt[d] = 0;
            esum[d] = '0;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    chk("reset_word_cnt", d, 32'(word_cnt_w[d]), 32'h0);
                    chk("reset_checksum", d, checksum_w[d], 32'h0);
                    prev[d] = '0;
                    ecnt[d] = 0;
                    esum[d] = '0;
                end else if (word_cnt_w[d] !== prev[d]) begin
                    if (sb[d].size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_commit dut%0d: word_cnt=%0d, expected %0d", d, word_cnt_w[d], prev[d]);
                    end else begin
                        h = sb[d].pop_front();
                        ecnt[d]++;
                        esum[d] = esum[d] + h[31:0];
                        sh[d][h[37:32]] = h[31:0];
                        sh_vld[d][h[37:32]] = 1'b1;
                        chk("commit_data", d, rd_data_w[d], h[31:0]);
                        chk("commit_word_cnt", d, 32'(word_cnt_w[d]), 32'(ecnt[d][15:0]));
                        chk("commit_checksum", d, checksum_w[d], esum[d]);
                    end
                    prev[d] = word_cnt_w[d];
                end
                rd_addr_v[d] = (sb[d].size() != 0) ? sb[d][0][37:32] : rb_idx;
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset();
        do_reset();
        repeat (10) idle();
        for (int d = 0; d < 2; d++) begin
            chk("idle_word_cnt", d, 32'(word_cnt_w[d]), 32'h0);
            chk("idle_checksum", d, checksum_w[d], 32'h0);
        end

        // Filtered commands: we low, then capture-window bit clear.
        cyc(1'b1, 1'b0, 9'h104, 32'h1111_1111, 1'b0);
        cyc(1'b1, 1'b1, 9'h004, 32'h2222_2222, 1'b0);
        repeat (3) idle();
        for (int d = 0; d < 2; d++) chk("filtered_word_cnt", d, 32'(word_cnt_w[d]), 32'h0);

        // Single write, readable two cycles after the exec cycle.
        rb_idx = 6'd1;
        cyc(1'b1, 1'b1, 9'h104, 32'hDEAD_BEEF, 1'b0);
        idle();
        chk("single_rd_data", 0, rd_data_w[0], 32'hDEAD_BEEF);
        chk("single_word_cnt", 0, 32'(word_cnt_w[0]), 32'h1);
        chk("single_checksum", 0, checksum_w[0], 32'hDEAD_BEEF);
        drain();

        // Overflow burst.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 9'(256 + 4 * i), $urandom, 1'b0);
        drain();
        chk("ovf_flag", 0, 32'(overflow_w[0]), 32'h1);
        chk("ovf_below_8", 0, 32'(word_cnt_w[0] < 16'd8), 32'h1);
        chk("ovf_accepted", 0, 32'(word_cnt_w[0]), 32'(m_acc[0]));
        repeat (5) idle();
        do_reset();

        // Full 64-word burst.
        for (int n = 0; n < 64; n++) cyc(1'b1, 1'b1, 9'(256 + 4 * n), 32'(n), 1'b0);
        drain();
        chk("burst_word_cnt", 1, 32'(word_cnt_w[1]), 32'd64);
        chk("burst_checksum", 1, checksum_w[1], 32'h7E0);
        chk("burst_overflow", 1, 32'(overflow_w[1]), 32'h0);
        readback(1'b1);

        // Reset with entries still queued.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 9'(256 + 4 * (i + 8)), 32'hA5A5_0000 + 32'(i), 1'b0);
        do_reset();
        for (int d = 0; d < 2; d++) chk("midrst_word_cnt", d, 32'(word_cnt_w[d]), 32'h0);
        repeat (4) idle();
        for (int d = 0; d < 2; d++) chk("midrst_no_drain", d, 32'(word_cnt_w[d]), 32'h0);
        readback(1'b0);

        // Randomised traffic with idle gaps.
        for (int i = 0; i < 400; i++) begin
            logic e;
            logic w;
            logic [8:0] a;
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(3, 10)) idle();
            end
            e = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 7) != 0);
            a = {1'($urandom_range(0, 7) != 0), 6'($urandom), 2'($urandom)};
            cyc(e, w, a, $urandom, 1'b0);
        end
        drain();
        readback(1'b0);
        for (int d = 0; d < 2; d++) begin
            chk("sb_empty", d, 32'(sb[d].size()), 32'h0);
            chk("final_word_cnt", d, 32'(word_cnt_w[d]), 32'(m_acc[d][15:0]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
